ncl_fullword_capture: RTL

- Downstream consumer for the 32-bit dual-rail full-word-completeness counter.
- Replaces the counter's auto-consume sum/carry completion logic and TH33 closure gate.
- Detects complete DATA and complete NULL wavefronts on the dual-rail sum and carry-out, and drives the completion/acknowledge signal back to the counter.
- Converts each DATA wavefront to a Boolean word and queues it into a clocked FIFO with a valid/ready output.

---
 rtl/ncl_fullword_capture.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ncl_fullword_capture.sv
// ncl_fullword_capture
// Clocked consumer for a 32-bit dual-rail full-word-completeness counter.
// It spots complete DATA and complete NULL wavefronts on the sum and carry
// rails, returns the completion/acknowledge to the counter, and queues each
// DATA wavefront as a Boolean word in a small valid/ready FIFO.
module ncl_fullword_capture #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       init_n,
    input  logic [2*WIDTH-1:0]         sum_dr,
    input  logic [1:0]                 cout_dr,
    output logic                       ack,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_cout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       illegal_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LVL_ONE  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    typedef enum logic {
        WAIT_DATA = 1'b0,
        WAIT_NULL = 1'b1
    } state_t;

    state_t                  state_r;
    logic                    ack_r;
    logic                    illegal_r;
    logic [SYNC_STAGES-1:0]  data_sync_r;
    logic [SYNC_STAGES-1:0]  null_sync_r;
    logic [WIDTH:0]          mem_r [DEPTH];
    logic [AW-1:0]           wr_ptr_r;
    logic [AW-1:0]           rd_ptr_r;
    logic [LW-1:0]           level_r;
    logic                    valid_r;

    logic                    data_cmp_s;
    logic                    null_cmp_s;
    logic                    illegal_s;
    logic [WIDTH-1:0]        word_s;
    logic                    data_s;
    logic                    null_s;
    logic                    full_s;
    logic                    push_s;
    logic                    pop_s;
    logic [LW-1:0]           level_next_s;
    logic [WIDTH:0]          head_s;

    // Wavefront detection and rail1 extraction over the sum pairs plus carry pair
    always_comb begin
        data_cmp_s = cout_dr[1] | cout_dr[0];
        null_cmp_s = ~(cout_dr[1] | cout_dr[0]);
        illegal_s  = cout_dr[1] & cout_dr[0];
        word_s     = '0;
        for (int k = 0; k < WIDTH; k++) begin
            data_cmp_s = data_cmp_s & (sum_dr[2*k+1] | sum_dr[2*k]);
            null_cmp_s = null_cmp_s & ~(sum_dr[2*k+1] | sum_dr[2*k]);
            illegal_s  = illegal_s | (sum_dr[2*k+1] & sum_dr[2*k]);
            word_s[k]  = sum_dr[2*k+1];
        end
    end

    // Synchronise both completion detectors into the capture clock domain
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            data_sync_r <= '0;
            null_sync_r <= '0;
        end else begin
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], data_cmp_s};
            null_sync_r <= {null_sync_r[SYNC_STAGES-2:0], null_cmp_s};
        end
    end

    // Capture happens on the WAIT_DATA->WAIT_NULL edge so ack and the new
    // FIFO head appear one cycle after the synchronised DATA indication.
    // The full decision looks only at the registered level, so a pop in
    // the same cycle cannot make room for this push.
    always_comb begin
        data_s = data_sync_r[SYNC_STAGES-1];
        null_s = null_sync_r[SYNC_STAGES-1];
        full_s = (level_r == LVL_FULL);
        push_s = (state_r == WAIT_DATA) && data_s && !full_s;
        pop_s  = valid_r && out_ready;
    end

    // Handshake FSM with registered ack and sticky illegal-encoding flag
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_r   <= WAIT_DATA;
            ack_r     <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            case (state_r)
                WAIT_DATA: begin
                    if (push_s) begin
                        state_r <= WAIT_NULL;
                        ack_r   <= 1'b1;
                        if (illegal_s) begin
                            illegal_r <= 1'b1;
                        end
                    end
                end
                WAIT_NULL: begin
                    if (null_s) begin
                        state_r <= WAIT_DATA;
                        ack_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= WAIT_DATA;
                    ack_r   <= 1'b0;
                end
            endcase
        end
    end

    // Next FIFO occupancy from the push/pop pair
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LVL_ONE;
            2'b01:   level_next_s = level_r - LVL_ONE;
            default: level_next_s = level_r;
        endcase
    end

    // FIFO pointers, occupancy and head-valid flag
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r <= level_next_s;
            valid_r <= (level_next_s != '0);
        end
    end

    // FIFO storage; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {cout_dr[1], word_s};
        end
    end

    // Present the head entry, forced to zero while the FIFO is empty
    always_comb begin
        if (valid_r) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = '0;
        end
    end

    assign ack         = ack_r;
    assign out_valid   = valid_r;
    assign out_data    = head_s[WIDTH-1:0];
    assign out_cout    = head_s[WIDTH];
    assign level       = level_r;
    assign illegal_err = illegal_r;

endmodule
